// File: rtl/note_track_pkg.sv
// rtl/note_track_pkg.sv - shared lane geometry, renderer lane colours and FSM encoding for the note track engine
package note_track_pkg;

  localparam int LANES          = 4;
  localparam int SLOTS_DEF      = 4;
  localparam int CHART_LEN_DEF  = 64;
  localparam int NOTE_W_DEF     = 50;
  localparam int NOTE_SPEED_DEF = 1;
  localparam int LANE_X0_DEF    = 170;
  localparam int LANE_PITCH_DEF = 100;
  localparam int VIDEO_H_DEF    = 480;

  // 12-bit RGB, index = lane: red, green, blue, grey
  localparam logic [LANES-1:0][11:0] LANE_RGB = {12'h888, 12'h00F, 12'h0F0, 12'hF00};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_FETCH,
    ST_LOAD
  } state_t;

  function automatic logic [10:0] lane_x(input int x0, input int pitch, input int k);
    return 11'(x0 + k * pitch);
  endfunction

endpackage

// File: rtl/note_lane.sv
// rtl/note_lane.sv - one lane of falling-note slots: advance/retire, lowest-free allocation, pixel hit test
module note_lane
  import note_track_pkg::*;
#(
  parameter int SLOTS      = SLOTS_DEF,
  parameter int NOTE_W     = NOTE_W_DEF,
  parameter int NOTE_SPEED = NOTE_SPEED_DEF,
  parameter int VIDEO_H    = VIDEO_H_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        move,
  input  logic        spawn,
  input  logic [10:0] lane_x,
  input  logic [9:0]  pix_x,
  input  logic [8:0]  pix_y,
  output logic        hit,
  output logic        retired,
  output logic        full
);

  localparam logic [9:0]  VH    = 10'(VIDEO_H);
  localparam logic [9:0]  SPEED = 10'(NOTE_SPEED);
  localparam logic [10:0] NW    = 11'(NOTE_W);

  logic [SLOTS-1:0] valid;
  logic [9:0]       y      [SLOTS];
  logic [9:0]       y_next [SLOTS];
  logic [SLOTS-1:0] retire;
  logic [SLOTS-1:0] alloc;
  logic             found;
  logic             x_in;

  always_comb begin
    alloc = '0;
    found = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      y_next[i] = y[i] + SPEED;
      retire[i] = valid[i] && (y_next[i] >= VH);
      if (!valid[i] && !found) begin
        alloc[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  // 11-bit compares so y + NOTE_W never wraps
  always_comb begin
    x_in = ({1'b0, pix_x} >= lane_x) && ({1'b0, pix_x} < (lane_x + NW));
    hit  = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (valid[i] && x_in && ({2'b0, pix_y} >= {1'b0, y[i]}) && ({2'b0, pix_y} < ({1'b0, y[i]} + NW)))
        hit = 1'b1;
    end
  end

  assign full = &valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid   <= '0;
      retired <= 1'b0;
      for (int i = 0; i < SLOTS; i++) y[i] <= '0;
    end else begin
      retired <= move && (|retire);
      for (int i = 0; i < SLOTS; i++) begin
        if (move && valid[i]) begin
          if (retire[i]) begin
            valid[i] <= 1'b0;
            y[i]     <= '0;
          end else begin
            y[i] <= y_next[i];
          end
        end else if (spawn && alloc[i]) begin
          valid[i] <= 1'b1;
          y[i]     <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/note_track_engine.sv
// rtl/note_track_engine.sv - 4-lane note tracker: tick arbitration FSM, chart ROM stepping, flags, registered hit output
// Build option NOTE_TRACK_LOOP_EN: chart address wraps to 0 instead of raising chart_done.
module note_track_engine
  import note_track_pkg::*;
#(
  parameter int SLOTS      = SLOTS_DEF,
  parameter int CHART_LEN  = CHART_LEN_DEF,
  parameter int NOTE_W     = NOTE_W_DEF,
  parameter int NOTE_SPEED = NOTE_SPEED_DEF,
  parameter int LANE_X0    = LANE_X0_DEF,
  parameter int LANE_PITCH = LANE_PITCH_DEF,
  parameter int VIDEO_H    = VIDEO_H_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         frame_tick,
  input  logic                         spawn_tick,
  output logic [$clog2(CHART_LEN)-1:0] chart_addr,
  input  logic [3:0]                   chart_data,
  input  logic [9:0]                   pix_x,
  input  logic [8:0]                   pix_y,
  output logic [3:0]                   in_lane,
  output logic [3:0]                   missed,
  output logic                         overflow,
  output logic                         chart_done
);

  localparam int              AW        = $clog2(CHART_LEN);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(CHART_LEN - 1);

  state_t           state, state_nx;
  logic             frame_pend, spawn_pend;
  logic             frame_req, spawn_req;
  logic             take_frame, take_spawn;
  logic             lane_move;
  logic [LANES-1:0] lane_spawn, hit, retired, full;

  assign frame_req  = frame_tick | frame_pend;
  assign spawn_req  = (spawn_tick | spawn_pend) & ~chart_done;
  assign lane_move  = (state == ST_MOVE);
  assign lane_spawn = (state == ST_LOAD) ? chart_data : '0;
  assign missed     = retired;

  // Frames always win over spawns; a frame arriving during MOVE is replayed via IDLE
  always_comb begin
    state_nx   = state;
    take_frame = 1'b0;
    take_spawn = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (frame_req) begin
          state_nx   = ST_MOVE;
          take_frame = 1'b1;
        end else if (spawn_req) begin
          state_nx   = ST_FETCH;
          take_spawn = 1'b1;
        end
      end
      ST_MOVE: begin
        if (!frame_tick && spawn_req) begin
          state_nx   = ST_FETCH;
          take_spawn = 1'b1;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_FETCH: state_nx = ST_LOAD;
      ST_LOAD:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      frame_pend <= 1'b0;
      spawn_pend <= 1'b0;
      chart_addr <= '0;
      chart_done <= 1'b0;
      overflow   <= 1'b0;
      in_lane    <= '0;
    end else begin
      state      <= state_nx;
      frame_pend <= frame_req & ~take_frame;
      spawn_pend <= spawn_req & ~take_spawn;
      in_lane    <= hit;
      if (state == ST_LOAD) begin
        overflow <= overflow | (|(chart_data & full));
        if (chart_addr == LAST_ADDR) begin
`ifdef NOTE_TRACK_LOOP_EN
          chart_addr <= '0;
`else
          chart_done <= 1'b1;
`endif
        end else begin
          chart_addr <= chart_addr + 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    note_lane #(
      .SLOTS      (SLOTS),
      .NOTE_W     (NOTE_W),
      .NOTE_SPEED (NOTE_SPEED),
      .VIDEO_H    (VIDEO_H)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .move    (lane_move),
      .spawn   (lane_spawn[k]),
      .lane_x  (lane_x(LANE_X0, LANE_PITCH, k)),
      .pix_x   (pix_x),
      .pix_y   (pix_y),
      .hit     (hit[k]),
      .retired (retired[k]),
      .full    (full[k])
    );
  end

endmodule
